// File: rtl/register_read_port.sv
// Two-operand read port for the 16 x 32-bit register bank.
// Registers both operands into a one-slot output stage with same-cycle write bypass.
module register_read_port (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_r0,
    input  logic [31:0] i_r1,
    input  logic [31:0] i_r2,
    input  logic [31:0] i_r3,
    input  logic [31:0] i_r4,
    input  logic [31:0] i_r5,
    input  logic [31:0] i_r6,
    input  logic [31:0] i_r7,
    input  logic [31:0] i_r8,
    input  logic [31:0] i_r9,
    input  logic [31:0] i_r10,
    input  logic [31:0] i_r11,
    input  logic [31:0] i_r12,
    input  logic [31:0] i_r13,
    input  logic [31:0] i_r14,
    input  logic [31:0] i_r15,
    input  logic [15:0] i_wr_sel,
    input  logic [31:0] i_wr_data,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_rs_sel,
    input  logic [3:0]  i_rt_sel,
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic        o_wr_sel_err,
    output logic [15:0] o_rd_count
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic        r_state;
    logic        w_state_next;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic        r_wr_sel_err;
    logic [15:0] r_rd_count;

    logic [31:0] w_bank [16];
    logic        w_wr_any;
    logic        w_wr_multi;
    logic        w_wr_onehot;
    logic        w_rs_bypass;
    logic        w_rt_bypass;
    logic [31:0] w_rs_operand;
    logic [31:0] w_rt_operand;
    logic        w_accept;

    assign w_bank[0]  = i_r0;
    assign w_bank[1]  = i_r1;
    assign w_bank[2]  = i_r2;
    assign w_bank[3]  = i_r3;
    assign w_bank[4]  = i_r4;
    assign w_bank[5]  = i_r5;
    assign w_bank[6]  = i_r6;
    assign w_bank[7]  = i_r7;
    assign w_bank[8]  = i_r8;
    assign w_bank[9]  = i_r9;
    assign w_bank[10] = i_r10;
    assign w_bank[11] = i_r11;
    assign w_bank[12] = i_r12;
    assign w_bank[13] = i_r13;
    assign w_bank[14] = i_r14;
    assign w_bank[15] = i_r15;

    // x & (x-1) clears the lowest set bit; non-zero result means two or more bits set.
    assign w_wr_any    = |i_wr_sel;
    assign w_wr_multi  = |(i_wr_sel & (i_wr_sel - 16'd1));
    assign w_wr_onehot = w_wr_any && !w_wr_multi;

    assign w_rs_bypass  = w_wr_onehot && i_wr_sel[i_rs_sel];
    assign w_rt_bypass  = w_wr_onehot && i_wr_sel[i_rt_sel];
    assign w_rs_operand = w_rs_bypass ? i_wr_data : w_bank[i_rs_sel];
    assign w_rt_operand = w_rt_bypass ? i_wr_data : w_bank[i_rt_sel];

    assign o_req_ready = (r_state == ST_EMPTY) || i_rd_ready;
    assign w_accept    = i_req_valid && o_req_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end else if (i_rd_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_EMPTY;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_wr_sel_err <= 1'b0;
            r_rd_count   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_multi) begin
                r_wr_sel_err <= 1'b1;
            end
            if (w_accept) begin
                r_rs_data  <= w_rs_operand;
                r_rt_data  <= w_rt_operand;
                r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign o_rd_valid   = (r_state == ST_FULL);
    assign o_rs_data    = r_rs_data;
    assign o_rt_data    = r_rt_data;
    assign o_wr_sel_err = r_wr_sel_err;
    assign o_rd_count   = r_rd_count;

endmodule

// File: tb/tb_register_read_port.sv
// Randomized bench for register_read_port with a behavioural operand/handshake model.
module tb_register_read_port;

    logic        clk;
    logic        reset_n;
    logic [31:0] r [16];
    logic [15:0] wr_sel;
    logic [31:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  rs_sel;
    logic [3:0]  rt_sel;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_sel_err;
    logic [15:0] rd_count;

    int checks;
    int failures;

    // Reference state
    bit          m_valid;
    bit [31:0]   m_rs;
    bit [31:0]   m_rt;
    bit          m_err;
    int          m_count;

    register_read_port u_dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_r0        (r[0]),
        .i_r1        (r[1]),
        .i_r2        (r[2]),
        .i_r3        (r[3]),
        .i_r4        (r[4]),
        .i_r5        (r[5]),
        .i_r6        (r[6]),
        .i_r7        (r[7]),
        .i_r8        (r[8]),
        .i_r9        (r[9]),
        .i_r10       (r[10]),
        .i_r11       (r[11]),
        .i_r12       (r[12]),
        .i_r13       (r[13]),
        .i_r14       (r[14]),
        .i_r15       (r[15]),
        .i_wr_sel    (wr_sel),
        .i_wr_data   (wr_data),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_rs_sel    (rs_sel),
        .i_rt_sel    (rt_sel),
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rs_data   (rs_data),
        .o_rt_data   (rt_data),
        .o_wr_sel_err(wr_sel_err),
        .o_rd_count  (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] operand(input int idx);
        if ($countones(wr_sel) == 1 && wr_sel[idx]) return wr_data;
        return r[idx];
    endfunction

    // One clock: checks req_ready, advances the model, then checks registered outputs.
    task automatic cycle();
        bit accept;
        #1;
        check("req_ready", {31'd0, req_ready}, {31'd0, (!m_valid || rd_ready)});
        if (!reset_n) begin
            m_valid = 0; m_rs = 0; m_rt = 0; m_err = 0; m_count = 0;
        end else begin
            accept = req_valid && (!m_valid || rd_ready);
            if ($countones(wr_sel) > 1) m_err = 1;
            if (accept) begin
                m_rs = operand(rs_sel);
                m_rt = operand(rt_sel);
                m_valid = 1;
                m_count = (m_count + 1) % 65536;
            end else if (m_valid && rd_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        check("rs_data", rs_data, m_rs);
        check("rt_data", rt_data, m_rt);
        check("wr_sel_err", {31'd0, wr_sel_err}, {31'd0, m_err});
        check("rd_count", {16'd0, rd_count}, m_count[31:0]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        wr_sel = 16'd0;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic randomize_bank();
        for (int i = 0; i < 16; i++) r[i] = $urandom;
    endtask

    function automatic logic [15:0] rand_wr_sel();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 16'd0;
        if (k == 1) return 16'd1 << $urandom_range(0, 15);
        return 16'($urandom);
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        req_valid = 1'b0;
        rd_ready = 1'b1;
        rs_sel = 4'd0;
        rt_sel = 4'd0;
        wr_sel = 16'd0;
        wr_data = 32'd0;
        for (int i = 0; i < 16; i++) r[i] = 32'd0;
        @(posedge clk);
        #1;
        m_valid = 0; m_rs = 0; m_rt = 0; m_err = 0; m_count = 0;
        do_reset();
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Basic read
        r[3] = 32'h33; r[9] = 32'h99;
        req_valid = 1; rs_sel = 3; rt_sel = 9; rd_ready = 1;
        cycle();
        check("basic_rs", rs_data, 32'h33);
        check("basic_rt", rt_data, 32'h99);
        check("basic_cnt", {16'd0, rd_count}, 32'd1);
        req_valid = 0;
        cycle();
        check("basic_drain", {31'd0, rd_valid}, 32'd0);

        // Bypass with rs == rt
        r[5] = 32'h11; wr_sel = 16'h0020; wr_data = 32'hABCD_0000;
        req_valid = 1; rs_sel = 5; rt_sel = 5;
        cycle();
        check("bypass_rs", rs_data, 32'hABCD_0000);
        check("bypass_rt", rt_data, 32'hABCD_0000);

        // Invalid select: no bypass, sticky error
        r[3] = 32'h3; wr_sel = 16'h0028; wr_data = 32'hFFFF_FFFF;
        rs_sel = 3; rt_sel = 5;
        cycle();
        check("inv_rs", rs_data, 32'h3);
        check("inv_err", {31'd0, wr_sel_err}, 32'd1);
        wr_sel = 16'd0; req_valid = 0;
        cycle();
        cycle();
        check("inv_sticky", {31'd0, wr_sel_err}, 32'd1);

        // Back-pressure hold, then replace without a bubble
        req_valid = 1; rs_sel = 4'd7; rt_sel = 4'd2; rd_ready = 1;
        cycle();
        rd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            randomize_bank();
            req_valid = 1'($urandom);
            wr_sel = rand_wr_sel();
            wr_data = $urandom;
            rs_sel = 4'($urandom);
            cycle();
            check("bp_hold_valid", {31'd0, rd_valid}, 32'd1);
        end
        wr_sel = 16'd0;
        req_valid = 1; rd_ready = 1; rs_sel = 4'd1; rt_sel = 4'd15;
        cycle();
        check("bp_release_valid", {31'd0, rd_valid}, 32'd1);

        // Streaming from a fresh reset
        do_reset();
        req_valid = 1; rd_ready = 1;
        for (int i = 0; i < 20; i++) begin
            randomize_bank();
            rs_sel = 4'(i % 16);
            rt_sel = 4'($urandom);
            cycle();
            check("stream_valid", {31'd0, rd_valid}, 32'd1);
        end
        check("stream_count", {16'd0, rd_count}, 32'd20);

        // Reset while holding
        rd_ready = 0;
        cycle();
        reset_n = 0;
        cycle();
        reset_n = 1; req_valid = 0;
        check("midrst_valid", {31'd0, rd_valid}, 32'd0);
        check("midrst_rs", rs_data, 32'd0);
        check("midrst_cnt", {16'd0, rd_count}, 32'd0);
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            randomize_bank();
            wr_sel = rand_wr_sel();
            wr_data = $urandom;
            req_valid = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 2) != 0);
            rs_sel = 4'($urandom);
            rt_sel = ($urandom_range(0, 4) == 0) ? rs_sel : 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
